pc_next_ctrl: RTL

Sequencing controller that drives the next-PC source mux and the PC write enable in the multicycle datapath. For each instruction it issues the PC+4 write at fetch, then resolves jumps, conditional branches and exceptions into one final, single-cycle PC update. On an exception it also pulses the EPC write and runs the handler-vector memory read. It sits between the main control FSM, which provides fetch/decode/resolve strobes, and the 5-input PC source mux.

---
 rtl/pc_next_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/pc_next_ctrl.sv
// pc_next_ctrl: sequences PC updates for one instruction in the multicycle
// datapath. It issues the fetch-time PC+4 write and then resolves jumps,
// conditional branches and exceptions into a single final PC update. On an
// exception it also pulses the EPC write and runs the handler-vector read.
// All outputs are decoded from registered state only (Moore).
module pc_next_ctrl #(
  parameter int MEM_LAT = 2  // vector read hold cycles, legal 1..15
) (
  input  logic       clk,
  input  logic       reset,          // asynchronous, active-low
  input  logic       fetch_req,
  input  logic       decode_valid,
  input  logic [2:0] br_type,
  input  logic       resolve_valid,
  input  logic       alu_zero,
  input  logic       alu_gt,
  input  logic       exc_overflow,
  input  logic       exc_divzero,
  output logic [2:0] pc_src,
  output logic       pc_write,
  output logic       epc_write,
  output logic       exc_mem_read,
  output logic [1:0] exc_addr_sel,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT_DEC, S_WAIT_RES,
    S_PCW, S_FIN, S_EXC_RD, S_EXC_LOAD
  } state_t;

  // Branch type encodings
  localparam logic [2:0] BR_SEQ = 3'b000;
  localparam logic [2:0] BR_BEQ = 3'b001;
  localparam logic [2:0] BR_BNE = 3'b010;
  localparam logic [2:0] BR_BLE = 3'b011;
  localparam logic [2:0] BR_BGT = 3'b100;
  localparam logic [2:0] BR_J   = 3'b101;
  localparam logic [2:0] BR_JR  = 3'b110;
  localparam logic [2:0] BR_INV = 3'b111;

  // PC source mux selects
  localparam logic [2:0] SRC_PC4 = 3'b000;
  localparam logic [2:0] SRC_BR  = 3'b001;
  localparam logic [2:0] SRC_J   = 3'b010;
  localparam logic [2:0] SRC_RS  = 3'b011;
  localparam logic [2:0] SRC_EXC = 3'b100;

  // Exception causes, doubling as vector address selects
  localparam logic [1:0] CAUSE_OPC = 2'b01;
  localparam logic [1:0] CAUSE_OVF = 2'b10;
  localparam logic [1:0] CAUSE_DVZ = 2'b11;

  // Counter load value: EXC_RD lasts MEM_LAT cycles, expiring at zero
  localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

  state_t     state_q, state_d;
  logic [2:0] sel_q,   sel_d;    // final PC source for PCW
  logic [2:0] br_q,    br_d;     // latched conditional branch type
  logic [1:0] cause_q, cause_d;  // latched exception cause
  logic [3:0] cnt_q,   cnt_d;    // vector read hold counter
  logic       taken;

  // Branch condition evaluated against the latched branch type
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    taken = 1'b0;
    case (br_q)
      BR_BEQ:  taken = alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BLE:  taken = alu_zero | !alu_gt;
      BR_BGT:  taken = alu_gt;
      default: taken = 1'b0;
    endcase
  end

  // Next-state logic; exceptions outrank the decode/resolve strobes
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    br_d    = br_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE:  if (fetch_req) state_d = S_FETCH;
      S_FETCH: state_d = S_WAIT_DEC;
      S_WAIT_DEC: begin
        if (decode_valid && br_type == BR_INV) begin
          state_d = S_EXC_RD; cause_d = CAUSE_OPC; cnt_d = LAT_M1;
        end else if (exc_overflow) begin
          state_d = S_EXC_RD; cause_d = CAUSE_OVF; cnt_d = LAT_M1;
        end else if (exc_divzero) begin
          state_d = S_EXC_RD; cause_d = CAUSE_DVZ; cnt_d = LAT_M1;
        end else if (decode_valid) begin
          case (br_type)
            BR_SEQ:  state_d = S_FIN;
            BR_J:    begin state_d = S_PCW; sel_d = SRC_J;  end
            BR_JR:   begin state_d = S_PCW; sel_d = SRC_RS; end
            default: begin state_d = S_WAIT_RES; br_d = br_type; end
          endcase
        end
      end
      S_WAIT_RES: begin
        if (exc_overflow) begin
          state_d = S_EXC_RD; cause_d = CAUSE_OVF; cnt_d = LAT_M1;
        end else if (exc_divzero) begin
          state_d = S_EXC_RD; cause_d = CAUSE_DVZ; cnt_d = LAT_M1;
        end else if (resolve_valid) begin
          if (taken) begin
            state_d = S_PCW; sel_d = SRC_BR;
          end else begin
            state_d = S_FIN;
          end
        end
      end
      S_PCW:   state_d = S_IDLE;
      S_FIN:   state_d = S_IDLE;
      S_EXC_RD: begin
        if (cnt_q == 4'd0) state_d = S_EXC_LOAD;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_EXC_LOAD: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // State and latched-context registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      sel_q   <= SRC_PC4;
      br_q    <= BR_SEQ;
      cause_q <= 2'b00;
      cnt_q   <= 4'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples the pre-edge values of the others.
      state_q <= state_d;
      sel_q   <= sel_d;
      br_q    <= br_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Moore output decode from state and latched context
  always_comb begin
    pc_src       = SRC_PC4;
    pc_write     = 1'b0;
    epc_write    = 1'b0;
    exc_mem_read = 1'b0;
    exc_addr_sel = 2'b00;
    busy         = (state_q != S_IDLE);
    done         = 1'b0;
    case (state_q)
      S_FETCH: pc_write = 1'b1;
      S_PCW: begin
        pc_src   = sel_q;
        pc_write = 1'b1;
        done     = 1'b1;
      end
      S_FIN:   done = 1'b1;
      S_EXC_RD: begin
        exc_mem_read = 1'b1;
        exc_addr_sel = cause_q;
        epc_write    = (cnt_q == LAT_M1);  // first cycle of the read
      end
      S_EXC_LOAD: begin
        pc_src   = SRC_EXC;
        pc_write = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
